smi_flit_scale_xn: RTL and testbench
====================================

Name: smi_flit_scale_xn

Overview:
- Parametrised SMI flit width expander: packs ScaleFactor consecutive input flits of FlitWidth bytes into one output flit of FlitWidth*ScaleFactor bytes.
- Generalises the fixed x2 scaler to x2/x4/x8. Early end-of-frame flushes a partially filled word.
- Sits between narrow SMI producers (e.g. 4-byte protocol engines) and wide SMI consumers (memory/AXI bridges).

Parameters:
FlitWidth, 4, input flit data width in bytes; power of two, 1..16.
ScaleFactor, 4, number of input flits per output flit; legal values 2, 4, 8; FlitWidth*ScaleFactor <= 128.
LaneBits, log2(ScaleFactor), derived; width of the lane counter.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
srst  input  1  synchronous reset, active high.
smiInReady  input  1  input flit valid.
smiInEofc  input  8  input end-of-frame control: 0 = mid-frame, 1..FlitWidth = last flit, value = valid byte count.
smiInData  input  FlitWidth*8  input flit data, byte 0 in bits [7:0].
smiInStop  output  1  input backpressure; an input beat transfers when smiInReady && !smiInStop.
smiOutReady  output  1  output flit valid, registered.
smiOutEofc  output  8  output end-of-frame control, registered.
smiOutData  output  FlitWidth*ScaleFactor*8  output flit data, registered.
smiOutStop  input  1  output backpressure; an output beat transfers when smiOutReady && !smiOutStop.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (srst).
- State:
  - accumulator register (FlitWidth*ScaleFactor*8 bits) with lane counter cnt (0..ScaleFactor-1);
  - accFull flag plus accEofc (8 bits);
  - output register with valid flag outV.
- Reset: cnt=0, accFull=0, accumulator=0, outV=0. Hence smiOutReady=0, smiOutEofc=0, smiOutData=0; smiInStop=0 from the first cycle after reset.
- Drain condition: drain = !outV || !smiOutStop.
- Stop: smiInStop = accFull && !drain. This is the only combinational path from smiOutStop; there are no other input-to-output combinational paths.
- Input beat accepted while accFull=0:
  - data written to lane cnt (bits [(cnt+1)*FlitWidth*8-1 : cnt*FlitWidth*8]);
  - if smiInEofc != 0: accFull<=1, accEofc <= cnt*FlitWidth + min(smiInEofc, FlitWidth), cnt<=0;
  - else if cnt == ScaleFactor-1: accFull<=1, accEofc<=0, cnt<=0;
  - else cnt<=cnt+1.
- smiInEofc > FlitWidth is clamped to FlitWidth.
- Partial word (early EOF): lanes above the terminating lane output zero. The accumulator is cleared on each transfer to the output register.
- Transfer: when accFull && drain, the output register loads the accumulator and accEofc, outV<=1, accFull<=0.
  - An input beat presented in the same cycle is accepted (stop low) and written to lane 0 of the cleared accumulator.
- Output consumed with no transfer pending: outV<=0. Output contents hold stable while smiOutReady && smiOutStop.
- Latency: the completing input beat appears at the output 2 cycles later when unstalled.
- Throughput: one input flit per cycle sustained when smiOutStop=0.
- Frame boundaries are preserved: a new frame always starts at lane 0; output flits never contain bytes from two frames.
- srst mid-frame discards the partial accumulator and the output register. The next accepted beat starts at lane 0.
- Idle with smiInReady=0: no state change; cnt persists across idle gaps mid-frame.

Test Plan:
- FlitWidth=4, ScaleFactor=4; 8 beats 0x00000000..0x00000007, last with eofc=4 -> two output flits: data 0x00000003_00000002_00000001_00000000 with eofc=0, then 0x..07_06_05_04 with eofc=16; smiInStop never asserted with smiOutStop=0.
- Same config; frame of 2 beats, second eofc=3 -> one output with lanes 2,3 zero, eofc=7; next frame's first beat lands in lane 0.
- Single-beat frame with eofc=1 -> output eofc=1, lanes 1..3 zero; eofc=9 input -> clamped, output eofc=4.
- Hold smiOutStop=1 for 20 cycles during streaming -> exactly one output word held stable, one word in the accumulator, smiInStop=1. Release -> no loss or duplication; sequence intact.
- Assert srst for 1 cycle after 3 beats of a frame -> smiOutReady=0 next cycle. A fresh 4-beat frame then outputs correctly from lane 0.
- Sweep ScaleFactor=2 and 8 with random smiInReady/smiOutStop gaps -> scoreboard byte stream and eofc match the reference model.

Source files
------------

// File: rtl/smi_flit_scale_xn.sv
// SMI flit width expander: packs ScaleFactor narrow flits into one wide flit.
// An early end-of-frame flushes a partially filled word with the unused upper lanes zeroed.
module smi_flit_scale_xn #(
    parameter int FlitWidth   = 4,
    parameter int ScaleFactor = 4,
    parameter int LaneBits    = $clog2(ScaleFactor)
) (
    input  logic                               clk,
    input  logic                               srst,
    input  logic                               smiInReady,
    input  logic [7:0]                         smiInEofc,
    input  logic [FlitWidth*8-1:0]             smiInData,
    output logic                               smiInStop,
    output logic                               smiOutReady,
    output logic [7:0]                         smiOutEofc,
    output logic [FlitWidth*ScaleFactor*8-1:0] smiOutData,
    input  logic                               smiOutStop
);

    localparam int                  FlitBits  = FlitWidth * 8;
    localparam int                  WordBits  = FlitWidth * ScaleFactor * 8;
    localparam logic [7:0]          FlitBytes = 8'(FlitWidth);
    localparam logic [LaneBits-1:0] LastLane  = LaneBits'(ScaleFactor - 1);

    logic [WordBits-1:0] acc, accNext;
    logic [LaneBits-1:0] cnt, cntNext;
    logic                accFull, accFullNext;
    logic [7:0]          accEofc, accEofcNext;
    logic [7:0]          laneBytes;
    logic                outV;
    logic                drain, accept, transfer;

    assign drain       = !outV || !smiOutStop;
    assign smiInStop   = accFull && !drain;
    assign accept      = smiInReady && !smiInStop;
    assign transfer    = accFull && drain;
    assign smiOutReady = outV;

    // cnt is always 0 while accFull is set, so a beat accepted alongside a
    // transfer lands in lane 0 of the freshly cleared accumulator.
    always_comb begin
        accNext     = transfer ? '0 : acc;
        cntNext     = cnt;
        accFullNext = accFull && !transfer;
        accEofcNext = accEofc;
        laneBytes   = (smiInEofc > FlitBytes) ? FlitBytes : smiInEofc;
        if (accept) begin
            accNext[cnt*FlitBits +: FlitBits] = smiInData;
            if (smiInEofc != 8'd0) begin
                accFullNext = 1'b1;
                accEofcNext = 8'(cnt) * FlitBytes + laneBytes;
                cntNext     = '0;
            end else if (cnt == LastLane) begin
                accFullNext = 1'b1;
                accEofcNext = 8'd0;
                cntNext     = '0;
            end else begin
                cntNext = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            acc        <= '0;
            cnt        <= '0;
            accFull    <= 1'b0;
            accEofc    <= 8'd0;
            outV       <= 1'b0;
            smiOutEofc <= 8'd0;
            smiOutData <= '0;
        end else begin
            acc     <= accNext;
            cnt     <= cntNext;
            accFull <= accFullNext;
            accEofc <= accEofcNext;
            if (transfer) begin
                smiOutData <= acc;
                smiOutEofc <= accEofc;
                outV       <= 1'b1;
            end else if (!smiOutStop) begin
                outV <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_smi_flit_scale_xn.sv
// Scoreboard bench for smi_flit_scale_xn at ScaleFactor 2, 4 and 8 (FlitWidth 4),
// using a byte-stream reference model and a monitor decoupled from the stimulus.
module tb_smi_flit_scale_xn;

    localparam int FW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : h
        localparam int SF = 2 << g;
        localparam int WB = FW * SF * 8;

        logic          srst = 1'b1, inReady = 1'b0, outStop = 1'b0;
        logic          inStop, outReady;
        logic [7:0]    inEofc = 8'd0, outEofc;
        logic [FW*8-1:0] inData = '0;
        logic [WB-1:0] outData;
        logic          hold = 1'b0, rndStop = 1'b0;
        bit            fin = 1'b0;

        logic [WB-1:0] expData[$];
        logic [7:0]    expEofc[$];
        logic [7:0]    curBytes[$];

        smi_flit_scale_xn #(.FlitWidth(FW), .ScaleFactor(SF)) dut (
            .clk(clk), .srst(srst),
            .smiInReady(inReady), .smiInEofc(inEofc), .smiInData(inData), .smiInStop(inStop),
            .smiOutReady(outReady), .smiOutEofc(outEofc), .smiOutData(outData), .smiOutStop(outStop)
        );

        // Reference: a frame is a byte stream cut into words of SF*FW bytes,
        // the last word zero-padded and tagged with its valid byte count.
        function automatic void modelBeat(input logic [FW*8-1:0] d, input logic [7:0] e);
            logic [WB-1:0] w;
            int n;
            for (int b = 0; b < FW; b++) curBytes.push_back(d[8*b +: 8]);
            if (e != 8'd0 || curBytes.size() == FW * SF) begin
                n = curBytes.size() / FW;
                expEofc.push_back(e == 8'd0 ? 8'd0 : 8'((n - 1) * FW + ((e > FW) ? FW : int'(e))));
                while (curBytes.size() < FW * SF) curBytes.push_back(8'h00);
                w = '0;
                for (int i = 0; i < FW * SF; i++) w[8*i +: 8] = curBytes[i];
                expData.push_back(w);
                curBytes.delete();
            end
        endfunction

        task automatic idle(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        task automatic sendBeat(input logic [FW*8-1:0] d, input logic [7:0] e);
            int  waitCnt;
            logic took;
            waitCnt = 0;
            took    = 1'b0;
            inReady = 1'b1;
            inData  = d;
            inEofc  = e;
            while (!took && waitCnt < 500) begin
                @(negedge clk);
                took = !inStop;
                @(posedge clk);
                #1;
                waitCnt++;
            end
            inReady = 1'b0;
            checks++;
            if (took) modelBeat(d, e);
            else begin
                errors++;
                $display("FAIL sf%0d accept_timeout: beat %h still stopped after %0d cycles, required acceptance", SF, d, waitCnt);
            end
        endtask

        task automatic sendFrame(input int len, input int lastEofc, input bit rndData, input int gapPct);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 99) < gapPct) idle($urandom_range(1, 3));
                sendBeat(rndData ? $urandom : (FW*8)'(i), (i == len - 1) ? 8'(lastEofc) : 8'd0);
            end
        endtask

        initial begin
            forever begin
                @(posedge clk);
                #1;
                outStop = hold ? 1'b1 : (rndStop ? ($urandom_range(0, 99) < 40) : 1'b0);
            end
        end

        initial begin
            logic [WB-1:0] prevData;
            logic [7:0]    prevEofc;
            logic          prevHeld;
            prevHeld = 1'b0;
            prevData = '0;
            prevEofc = 8'd0;
            forever begin
                @(negedge clk);
                if (srst) prevHeld = 1'b0;
                else begin
                    if (prevHeld) begin
                        checks++;
                        if (!outReady || outData !== prevData || outEofc !== prevEofc) begin
                            errors++;
                            $display("FAIL sf%0d hold_stable: got v=%b eofc=%0d data=%h, required v=1 eofc=%0d data=%h",
                                     SF, outReady, outEofc, outData, prevEofc, prevData);
                        end
                    end
                    checks++;
                    if (inStop && (!outReady || !outStop)) begin
                        errors++;
                        $display("FAIL sf%0d stop_path: smiInStop=1 with outReady=%b outStop=%b, required 0", SF, outReady, outStop);
                    end
                    if (outReady && !outStop) begin
                        checks++;
                        if (expData.size() == 0) begin
                            errors++;
                            $display("FAIL sf%0d unexpected_output: got eofc=%0d data=%h, required no output", SF, outEofc, outData);
                        end else begin
                            logic [WB-1:0] wd;
                            logic [7:0]    we;
                            wd = expData.pop_front();
                            we = expEofc.pop_front();
                            if (outData !== wd || outEofc !== we) begin
                                errors++;
                                $display("FAIL sf%0d out_word: got eofc=%0d data=%h, required eofc=%0d data=%h",
                                         SF, outEofc, outData, we, wd);
                            end
                        end
                    end
                    prevHeld = outReady && outStop;
                    prevData = outData;
                    prevEofc = outEofc;
                end
            end
        end

        initial begin
            int t;
            idle(3);
            srst = 1'b0;
            @(negedge clk);
            checks++;
            if (outReady !== 1'b0 || outEofc !== 8'd0 || outData !== '0 || inStop !== 1'b0) begin
                errors++;
                $display("FAIL sf%0d reset_state: got v=%b eofc=%0d data=%h stop=%b, required all zero",
                         SF, outReady, outEofc, outData, inStop);
            end
            @(posedge clk);
            #1;

            sendFrame(2 * SF, FW, 1'b0, 0);
            sendFrame(2, 3, 1'b0, 0);
            sendFrame(SF + 1, 2, 1'b1, 0);
            sendFrame(1, 1, 1'b1, 0);
            sendFrame(1, 9, 1'b1, 0);
            idle(10);

            fork
                begin
                    hold = 1'b1;
                    idle(2 * SF + 20);
                    @(negedge clk);
                    checks++;
                    if (inStop !== 1'b1 || outReady !== 1'b1) begin
                        errors++;
                        $display("FAIL sf%0d stall_full: got stop=%b v=%b, required stop=1 v=1", SF, inStop, outReady);
                    end
                    hold = 1'b0;
                end
                sendFrame(3 * SF, FW, 1'b1, 0);
            join
            idle(10);

            for (int i = 0; i < SF - 1; i++) sendBeat($urandom, 8'd0);
            srst = 1'b1;
            expData.delete();
            expEofc.delete();
            curBytes.delete();
            idle(1);
            srst = 1'b0;
            @(negedge clk);
            checks++;
            if (outReady !== 1'b0) begin
                errors++;
                $display("FAIL sf%0d reset_midframe: got smiOutReady=%b, required 0", SF, outReady);
            end
            @(posedge clk);
            #1;
            sendFrame(SF, FW, 1'b1, 0);
            idle(5);

            rndStop = 1'b1;
            repeat (40) sendFrame($urandom_range(1, 2 * SF + 1), $urandom_range(1, FW + 5), 1'b1, 30);
            rndStop = 1'b0;
            t = 0;
            while (expData.size() != 0 && t < 200) begin
                idle(1);
                t++;
            end
            idle(3);
            checks++;
            if (expData.size() != 0 || curBytes.size() != 0) begin
                errors++;
                $display("FAIL sf%0d drain: %0d words and %0d bytes outstanding, required 0",
                         SF, expData.size(), curBytes.size());
            end
            fin = 1'b1;
        end
    end

    initial begin
        fork
            wait (h[0].fin && h[1].fin && h[2].fin);
            begin
                #500000;
                checks++;
                errors++;
                $display("FAIL global_timeout: fin=%b%b%b, required 111", h[2].fin, h[1].fin, h[0].fin);
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
